hd_text_sequencer: RTL and testbench

Synthesizable initiator for the `hyperdimensional_module` query protocol. It accepts a stream of ASCII text bytes over a valid/ready handshake and drives the module through one full query per text:

- letter feed,
- `textDone`,
- `computeAngle` and the index sweep,
- `argmax`,
- wait for `done`.

It returns `bestMatchID` over a second valid/ready handshake. The block sits between a host byte source (DMA/UART) and the HD classifier, replacing the simulation-only driver.

---
 rtl/hd_text_sequencer_pkg.sv | 25 ++
 rtl/hd_text_sequencer_char_map.sv | 25 ++
 rtl/hd_text_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_hd_text_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_text_sequencer_pkg.sv
// Shared types and constants for the HD text sequencer: FSM states, ASCII
// landmarks and the letter code reserved for the space character.
package hd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    FLUSH,
    START,
    COUNT,
    SETTLE,
    WAIT,
    RESULT
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'd32;
  localparam logic [7:0] ASCII_A     = 8'd97;
  localparam logic [7:0] ASCII_Z     = 8'd122;

  // Space takes the last slot of the letter alphabet.
  function automatic logic [4:0] space_code(input int unsigned maxletters);
    return 5'(maxletters - 1);
  endfunction

endpackage

// File: rtl/hd_text_sequencer_char_map.sv
// Combinational ASCII-to-letter-code mapper: 'a'..'z' -> 0..25, space -> the
// reserved space code, anything else flagged as unknown.
module hd_char_map
  import hd_pkg::*;
#(
  parameter int MAXLETTERS = 27
) (
  input  logic [7:0] char_data,
  output logic [4:0] code,
  output logic       known
);

  always_comb begin
    code  = '0;
    known = 1'b0;
    if (char_data >= ASCII_A && char_data <= ASCII_Z) begin
      code  = 5'(char_data - ASCII_A);
      known = 1'b1;
    end else if (char_data == ASCII_SPACE) begin
      code  = space_code(MAXLETTERS);
      known = 1'b1;
    end
  end

endmodule

// File: rtl/hd_text_sequencer.sv
// Drives one full hyperdimensional_module query per incoming text: letter
// feed, textDone, similarity sweep, argmax, then returns the winning ID.
module hd_text_sequencer
  import hd_pkg::*;
#(
  parameter int N           = 10000,
  parameter int PRECISION   = $clog2(N),
  parameter int MAXLETTERS  = 27,
  parameter int NUMLANG     = 22,
  parameter int LOG_NUMLANG = $clog2(NUMLANG),
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   char_valid,
  input  logic [7:0]             char_data,
  input  logic                   char_last,
  output logic                   char_ready,
  output logic                   letterReady,
  output logic [4:0]             inputLetter,
  output logic                   textDone,
  output logic                   rst_RI,
  output logic                   computeAngle,
  output logic [PRECISION-1:0]   index,
  output logic                   argmax,
  input  logic                   done,
  input  logic [LOG_NUMLANG-1:0] bestMatchID,
  output logic                   result_valid,
  output logic [LOG_NUMLANG-1:0] result_id,
  output logic                   result_err,
  input  logic                   result_ready,
  output logic [15:0]            unknown_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e                 state_q, state_d;
  logic                   char_ready_q, char_ready_d;
  logic                   letter_ready_q, letter_ready_d;
  logic [4:0]             input_letter_q, input_letter_d;
  logic                   text_done_q, text_done_d;
  logic                   rst_ri_q, rst_ri_d;
  logic                   compute_angle_q, compute_angle_d;
  logic [PRECISION-1:0]   index_q, index_d;
  logic                   argmax_q, argmax_d;
  logic                   result_valid_q, result_valid_d;
  logic [LOG_NUMLANG-1:0] result_id_q, result_id_d;
  logic                   result_err_q, result_err_d;
  logic [15:0]            unknown_q, unknown_d;
  logic                   settle_q, settle_d;
  logic [TW-1:0]          wait_q, wait_d;

  logic [4:0] map_code;
  logic       map_known;
  logic       accept;

  hd_char_map #(.MAXLETTERS(MAXLETTERS)) u_map (
    .char_data (char_data),
    .code      (map_code),
    .known     (map_known)
  );

  assign accept = char_valid & char_ready_q;

  always_comb begin
    state_d         = state_q;
    letter_ready_d  = 1'b0;
    input_letter_d  = input_letter_q;
    text_done_d     = 1'b0;
    compute_angle_d = 1'b0;
    index_d         = index_q;
    argmax_d        = argmax_q;
    rst_ri_d        = rst_ri_q;
    result_valid_d  = result_valid_q;
    result_id_d     = result_id_q;
    result_err_d    = result_err_q;
    unknown_d       = unknown_q;
    settle_d        = settle_q;
    wait_d          = wait_q;

    case (state_q)
      IDLE: begin
        rst_ri_d = 1'b0;
        if (accept) begin
          rst_ri_d  = 1'b1;
          unknown_d = map_known ? 16'd0 : 16'd1;
          if (map_known) begin
            letter_ready_d = 1'b1;
            input_letter_d = map_code;
          end
          state_d = char_last ? FLUSH : FEED;
        end
      end
      FEED: begin
        if (accept) begin
          if (map_known) begin
            letter_ready_d = 1'b1;
            input_letter_d = map_code;
          end else begin
            unknown_d = sat_inc16(unknown_q);
          end
          if (char_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        text_done_d = 1'b1;
        state_d     = START;
      end
      START: begin
        compute_angle_d = 1'b1;
        index_d         = '0;
        state_d         = COUNT;
      end
      COUNT: begin
        // Index parks at N-1; argmax is raised first, the state moves on a cycle later.
        if (index_q == PRECISION'(N - 1)) begin
          argmax_d = 1'b1;
          if (argmax_q) begin
            settle_d = 1'b0;
            state_d  = SETTLE;
          end
        end else begin
          index_d = index_q + PRECISION'(1);
        end
      end
      SETTLE: begin
        if (settle_q) begin
          wait_d  = '0;
          state_d = WAIT;
        end else begin
          settle_d = 1'b1;
        end
      end
      WAIT: begin
        if (done) begin
          result_id_d    = bestMatchID;
          result_err_d   = 1'b0;
          argmax_d       = 1'b0;
          result_valid_d = 1'b1;
          state_d        = RESULT;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          result_id_d    = '0;
          result_err_d   = 1'b1;
          argmax_d       = 1'b0;
          result_valid_d = 1'b1;
          state_d        = RESULT;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      RESULT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          rst_ri_d       = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    char_ready_d = (state_d == IDLE) || (state_d == FEED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      char_ready_q    <= 1'b0;
      letter_ready_q  <= 1'b0;
      input_letter_q  <= '0;
      text_done_q     <= 1'b0;
      rst_ri_q        <= 1'b0;
      compute_angle_q <= 1'b0;
      index_q         <= '0;
      argmax_q        <= 1'b0;
      result_valid_q  <= 1'b0;
      result_id_q     <= '0;
      result_err_q    <= 1'b0;
      unknown_q       <= '0;
      settle_q        <= 1'b0;
      wait_q          <= '0;
    end else begin
      state_q         <= state_d;
      char_ready_q    <= char_ready_d;
      letter_ready_q  <= letter_ready_d;
      input_letter_q  <= input_letter_d;
      text_done_q     <= text_done_d;
      rst_ri_q        <= rst_ri_d;
      compute_angle_q <= compute_angle_d;
      index_q         <= index_d;
      argmax_q        <= argmax_d;
      result_valid_q  <= result_valid_d;
      result_id_q     <= result_id_d;
      result_err_q    <= result_err_d;
      unknown_q       <= unknown_d;
      settle_q        <= settle_d;
      wait_q          <= wait_d;
    end
  end

  assign char_ready    = char_ready_q;
  assign letterReady   = letter_ready_q;
  assign inputLetter   = input_letter_q;
  assign textDone      = text_done_q;
  assign rst_RI        = rst_ri_q;
  assign computeAngle  = compute_angle_q;
  assign index         = index_q;
  assign argmax        = argmax_q;
  assign result_valid  = result_valid_q;
  assign result_id     = result_id_q;
  assign result_err    = result_err_q;
  assign unknown_count = unknown_q;

endmodule

// File: tb/tb_hd_text_sequencer.sv
// Directed bench for hd_text_sequencer with N=16, TIMEOUT=8; timing is checked
// relative to the edge that accepts the last byte of each text.
module tb_hd_text_sequencer;

  localparam int N    = 16;
  localparam int PREC = 4;
  localparam int LOGL = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            char_valid = 1'b0;
  logic [7:0]      char_data = '0;
  logic            char_last = 1'b0;
  logic            char_ready;
  logic            letterReady;
  logic [4:0]      inputLetter;
  logic            textDone;
  logic            rst_RI;
  logic            computeAngle;
  logic [PREC-1:0] index;
  logic            argmax;
  logic            done = 1'b0;
  logic [LOGL-1:0] bestMatchID = '0;
  logic            result_valid;
  logic [LOGL-1:0] result_id;
  logic            result_err;
  logic            result_ready = 1'b0;
  logic [15:0]     unknown_count;

  hd_text_sequencer #(
    .N(N), .MAXLETTERS(27), .NUMLANG(22), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .char_valid(char_valid), .char_data(char_data), .char_last(char_last),
    .char_ready(char_ready),
    .letterReady(letterReady), .inputLetter(inputLetter),
    .textDone(textDone), .rst_RI(rst_RI), .computeAngle(computeAngle),
    .index(index), .argmax(argmax),
    .done(done), .bestMatchID(bestMatchID),
    .result_valid(result_valid), .result_id(result_id), .result_err(result_err),
    .result_ready(result_ready), .unknown_count(unknown_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: obs = number of the edge whose register values are visible now.
  int   t_last = -1000;
  int   lr_n = 0;
  int   lr_code [0:255];
  int   lr_obs  [0:255];
  logic td_log [0:63];
  logic ca_log [0:63];
  logic am_log [0:63];
  logic rv_log [0:63];
  int   idx_log [0:63];
  int   mon_obs, mon_off;

  always @(negedge clk) begin
    mon_obs = cyc + 1;
    if (char_valid && char_ready && char_last) t_last = mon_obs;
    if (letterReady && lr_n < 256) begin
      lr_code[lr_n] = int'(inputLetter);
      lr_obs[lr_n]  = mon_obs;
      lr_n++;
    end
    mon_off = mon_obs - t_last;
    if (mon_off >= 0 && mon_off < 64) begin
      td_log[mon_off]  = textDone;
      ca_log[mon_off]  = computeAngle;
      am_log[mon_off]  = argmax;
      rv_log[mon_off]  = result_valid;
      idx_log[mon_off] = int'(index);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (cyc < target) chk("wait_bound", cyc, target);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int g;
    char_valid = 1'b1;
    char_data  = b;
    char_last  = last;
    g = 0;
    while (!char_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!char_ready) chk("char_ready_bound", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_text(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], (i == s.len() - 1));
    char_valid = 1'b0;
    char_last  = 1'b0;
  endtask

  int base, t;

  initial begin
    // Reset state
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_char_ready", char_ready, 0);
    chk("rst_rst_RI", rst_RI, 0);
    chk("rst_letterReady", letterReady, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_index", index, 0);
    chk("rst_argmax", argmax, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_char_ready", char_ready, 1);

    // Text "ab c": letter codes, textDone/computeAngle, sweep, argmax, result
    base = lr_n;
    send_text("ab c");
    t = t_last;
    chk("s1_rst_RI", rst_RI, 1);
    wait_cyc(t + 24);
    done = 1'b1; bestMatchID = 5'd7;
    @(posedge clk); #1;
    done = 1'b0; bestMatchID = 5'd0;
    wait_cyc(t + 28);
    chk("s1_lr_count", lr_n - base, 4);
    chk("s1_code0", lr_code[base],     0);
    chk("s1_code1", lr_code[base + 1], 1);
    chk("s1_code2", lr_code[base + 2], 26);
    chk("s1_code3", lr_code[base + 3], 2);
    for (int i = 0; i < 4; i++)
      chk($sformatf("s1_lr_time%0d", i), lr_obs[base + i], t - 2 + i);
    chk("s1_td_t1", td_log[1], 0);
    chk("s1_td_t2", td_log[2], 1);
    chk("s1_td_t3", td_log[3], 0);
    chk("s1_ca_t3", ca_log[3], 1);
    chk("s1_ca_t4", ca_log[4], 0);
    for (int k = 0; k < N; k++)
      chk($sformatf("s1_index_k%0d", k), idx_log[3 + k], k);
    chk("s1_index_hold", idx_log[21], N - 1);
    chk("s1_argmax_t18", am_log[18], 0);
    chk("s1_argmax_t19", am_log[19], 1);
    chk("s1_argmax_t21", am_log[21], 1);
    chk("s1_argmax_t25", am_log[25], 1);
    chk("s1_argmax_t26", am_log[26], 0);
    chk("s1_rv_t25", rv_log[25], 0);
    chk("s1_rv_t26", rv_log[26], 1);
    chk("s1_result_id", result_id, 7);
    chk("s1_result_err", result_err, 0);
    chk("s1_char_ready_busy", char_ready, 0);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("s1_rv_cleared", result_valid, 0);
    chk("s1_rst_RI_cleared", rst_RI, 0);
    @(posedge clk); #1;
    chk("s1_idle_char_ready", char_ready, 1);

    // "A1x": unknown bytes dropped; no done -> timeout; result held 4 cycles
    base = lr_n;
    send_text("A1x");
    t = t_last;
    chk("s2_unknown_count", unknown_count, 2);
    wait_cyc(t + 35);
    chk("s2_lr_count", lr_n - base, 1);
    chk("s2_code", lr_code[base], 23);
    chk("s2_lr_time", lr_obs[base], t + 1);
    chk("s2_rv_t29", rv_log[29], 0);
    chk("s2_rv_t30", rv_log[30], 1);
    for (int i = 31; i < 35; i++)
      chk($sformatf("s2_rv_hold%0d", i), rv_log[i], 1);
    chk("s2_result_err", result_err, 1);
    chk("s2_result_id", result_id, 0);
    chk("s2_char_ready_held", char_ready, 0);
    chk("s2_rst_RI_held", rst_RI, 1);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("s2_rst_RI_cleared", rst_RI, 0);
    chk("s2_rv_cleared", result_valid, 0);

    // Empty text "!" with result_ready held high throughout
    base = lr_n;
    result_ready = 1'b1;
    send_text("!");
    t = t_last;
    chk("s3_unknown_count", unknown_count, 1);
    wait_cyc(t + 22);
    done = 1'b1; bestMatchID = 5'd21;
    @(posedge clk); #1;
    done = 1'b0; bestMatchID = 5'd0;
    wait_cyc(t + 27);
    result_ready = 1'b0;
    chk("s3_lr_count", lr_n - base, 0);
    chk("s3_td_t2", td_log[2], 1);
    chk("s3_ca_t3", ca_log[3], 1);
    chk("s3_rv_t20", rv_log[20], 0);
    chk("s3_rv_t23", rv_log[23], 0);
    chk("s3_rv_t24", rv_log[24], 1);
    chk("s3_rv_t25", rv_log[25], 0);
    chk("s3_result_id", result_id, 21);
    chk("s3_result_err", result_err, 0);
    chk("s3_char_ready", char_ready, 1);

    // Reset asserted mid-sweep at index=5
    send_text("z");
    t = t_last;
    wait_cyc(t + 7);
    chk("s4_index_pre", index, 5);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("s4_index", index, 0);
    chk("s4_argmax", argmax, 0);
    chk("s4_char_ready", char_ready, 0);
    chk("s4_rst_RI", rst_RI, 0);
    chk("s4_computeAngle", computeAngle, 0);
    chk("s4_result_valid", result_valid, 0);
    chk("s4_unknown", unknown_count, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("s4_char_ready_after", char_ready, 1);
    chk("s4_index_after", index, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
